// File: rtl/demux_stream_sched.sv
// Packet-aware 1-to-N stream scheduler: per-packet destination chosen at the head beat
// (explicit or round-robin), locked until the last beat, with one registered output stage.
module demux_stream_sched #(
  parameter int DW = 8,
  parameter int N  = 3,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  input  logic [SW-1:0] in_dest_i,
  output logic [N-1:0]  out_valid_o,
  input  logic [N-1:0]  out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          drop_err_o
);

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [SW:0]   NUM_PORTS = N[SW:0];
  localparam int            LAST_INT  = N - 1;
  localparam logic [SW-1:0] LAST_IDX  = LAST_INT[SW-1:0];

  state_e        state_q;
  logic [SW-1:0] rr_ptr_q;
  logic [SW-1:0] lock_dest_q;
  logic          lock_rr_q;
  logic          buf_valid_q;
  logic [SW-1:0] buf_dest_q;
  logic [DW-1:0] buf_data_q;
  logic          buf_last_q;
  logic          drop_err_q;

  logic [SW-1:0] head_dest_s;
  logic          head_legal_s;
  logic          buf_fire_s;
  logic          buf_space_s;
  logic          in_ready_s;
  logic          accept_s;
  logic [N-1:0]  out_valid_s;

  function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] ptr);
    rr_next = (ptr == LAST_IDX) ? '0 : ptr + SW'(1);
  endfunction

  // Head decision, buffer occupancy and input handshake.
  always_comb begin
    head_dest_s  = mode_i ? rr_ptr_q : in_dest_i;
    head_legal_s = ({1'b0, head_dest_s} < NUM_PORTS);
    buf_fire_s   = buf_valid_q & out_ready_i[buf_dest_q];
    buf_space_s  = ~buf_valid_q | buf_fire_s;
    case (state_q)
      ST_HEAD: begin
        if (head_legal_s) begin
          in_ready_s = buf_space_s;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_BODY: in_ready_s = buf_space_s;
      ST_DROP: in_ready_s = 1'b1;
      default: in_ready_s = 1'b1;
    endcase
    accept_s = in_valid_i & in_ready_s;
  end

  // Decode the buffered destination onto the one-hot valid vector.
  always_comb begin
    out_valid_s = '0;
    for (int i = 0; i < N; i++) begin
      out_valid_s[i] = buf_valid_q & (buf_dest_q == SW'(i));
    end
  end

  // Packet FSM, round-robin pointer and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HEAD;
      rr_ptr_q    <= '0;
      lock_dest_q <= '0;
      lock_rr_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_dest_q  <= '0;
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      drop_err_q <= 1'b0;
      if (buf_fire_s) begin
        buf_valid_q <= 1'b0;
      end
      if (accept_s) begin
        case (state_q)
          ST_HEAD: begin
            if (head_legal_s) begin
              buf_valid_q <= 1'b1;
              buf_dest_q  <= head_dest_s;
              buf_data_q  <= in_data_i;
              buf_last_q  <= in_last_i;
              if (!in_last_i) begin
                lock_dest_q <= head_dest_s;
                lock_rr_q   <= mode_i;
                state_q     <= ST_BODY;
              end else if (mode_i) begin
                rr_ptr_q <= rr_next(rr_ptr_q);
              end
            end else begin
              drop_err_q <= 1'b1;
              if (!in_last_i) begin
                state_q <= ST_DROP;
              end
            end
          end
          ST_BODY: begin
            buf_valid_q <= 1'b1;
            buf_dest_q  <= lock_dest_q;
            buf_data_q  <= in_data_i;
            buf_last_q  <= in_last_i;
            if (in_last_i) begin
              state_q <= ST_HEAD;
              if (lock_rr_q) begin
                rr_ptr_q <= rr_next(rr_ptr_q);
              end
            end
          end
          ST_DROP: begin
            if (in_last_i) begin
              state_q <= ST_HEAD;
            end
          end
          default: state_q <= ST_HEAD;
        endcase
      end
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_s;
  assign out_data_o  = buf_data_q;
  assign out_last_o  = buf_last_q;
  assign drop_err_o  = drop_err_q;

endmodule

// File: tb/tb_demux_stream_sched.sv
// Randomized scoreboard bench: a packet-level reference model predicts every output beat
// and drop pulse; a monitor process compares what the DUT presents.
module tb_demux_stream_sched;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int NUM_PKTS  = 300;
  localparam int RESET_PKT = 150;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [SW-1:0] in_dest = '0;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready = '0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          drop_err;

  demux_stream_sched #(.DW(DW), .N(N), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (mode),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_dest_i  (in_dest),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .drop_err_o (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    bit            last;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   stall_phase = 1'b0;

  // Reference model state, at packet granularity.
  int rr_count = 0;
  bit in_pkt = 1'b0;
  bit pkt_dropped = 1'b0;
  int pkt_port = 0;
  bit pkt_rr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: mostly random, with occasional stretches of all-stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) stall_phase = ~stall_phase;
      if (stall_phase) out_ready = '0;
      else out_ready = N'($urandom_range(0, (1 << N) - 1)) | N'($urandom_range(0, (1 << N) - 1));
    end
  end

  // Model: a beat the DUT is about to accept at the next rising edge.
  task automatic model_accept();
    int d;
    exp_t e;
    e.data = in_data;
    e.last = in_last;
    e.cyc  = cyc + 1;
    if (!in_pkt) begin
      d = mode ? (rr_count % N) : int'(in_dest);
      if (d >= N) begin
        drop_q.push_back(cyc + 1);
        if (!in_last) begin
          in_pkt = 1'b1;
          pkt_dropped = 1'b1;
        end
      end else begin
        e.port = d;
        exp_q.push_back(e);
        if (!in_last) begin
          in_pkt = 1'b1;
          pkt_dropped = 1'b0;
          pkt_port = d;
          pkt_rr = mode;
        end else if (mode) begin
          rr_count++;
        end
      end
    end else if (pkt_dropped) begin
      if (in_last) in_pkt = 1'b0;
    end else begin
      e.port = pkt_port;
      exp_q.push_back(e);
      if (in_last) begin
        in_pkt = 1'b0;
        if (pkt_rr) rr_count++;
      end
    end
  endtask

  // Present one beat and hold it until accepted; checks in_ready against the model.
  task automatic send_beat(input bit head, input bit m, input logic [SW-1:0] d,
                           input bit last);
    bit exp_ready;
    bit dropping;
    bit done = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      mode = 1'($urandom);
      in_dest = SW'($urandom);
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    in_last  = last;
    mode     = head ? m : 1'($urandom);
    in_dest  = head ? d : SW'($urandom);
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      dropping  = in_pkt ? pkt_dropped : (!mode && int'(in_dest) >= N);
      exp_ready = dropping || (out_valid == '0) || ((out_valid & out_ready) != '0);
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
      end
      if (in_ready) begin
        model_accept();
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout cyc=%0d got=not_accepted exp=accepted", cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    drop_q.delete();
    rr_count = 0;
    in_pkt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== '0 || drop_err !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b drop=%b rdy=%b data=%h exp valid=000 drop=0 rdy=1 data=00",
               out_valid, drop_err, in_ready, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares presented outputs and drop pulses against the scoreboard.
  initial begin
    logic [N-1:0] expv;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drop_err) begin
          checks++;
          if (drop_q.size() == 0 || drop_q[0] != cyc) begin
            failures++;
            $display("FAIL drop_pulse cyc=%0d got=1 exp=0", cyc);
          end else begin
            void'(drop_q.pop_front());
          end
        end else if (drop_q.size() != 0 && drop_q[0] <= cyc) begin
          checks++;
          failures++;
          $display("FAIL drop_missing cyc=%0d got=0 exp=1", cyc);
          void'(drop_q.pop_front());
        end
        if (out_valid != '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected cyc=%0d got valid=%b exp=none", cyc, out_valid);
          end else begin
            expv = '0;
            expv[exp_q[0].port] = 1'b1;
            if (out_valid !== expv || out_data !== exp_q[0].data || out_last !== exp_q[0].last) begin
              failures++;
              $display("FAIL out_beat cyc=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b", cyc,
                       out_valid, out_data, out_last, expv, exp_q[0].data, exp_q[0].last);
            end
            if ((out_valid & out_ready) != '0) void'(exp_q.pop_front());
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          checks++;
          failures++;
          $display("FAIL out_latency cyc=%0d got valid=000 exp port=%0d", cyc, exp_q[0].port);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus: random packets of 1..4 beats, explicit or round-robin routing.
  initial begin
    int  len;
    bit  m;
    bit  force_rr = 1'b0;
    logic [SW-1:0] d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      len = $urandom_range(1, 4);
      m   = force_rr ? 1'b1 : 1'($urandom);
      d   = SW'($urandom);
      force_rr = 1'b0;
      if (p == RESET_PKT) begin
        len = 3;
        m = 1'b1;
      end
      for (int b = 0; b < len; b++) begin
        if (p == RESET_PKT && b == 1) begin
          do_reset();
          force_rr = 1'b1;
          break;
        end
        send_beat(b == 0, m, d, b == len - 1);
      end
    end
    for (int t = 0; t < 200 && (exp_q.size() != 0 || drop_q.size() != 0); t++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || drop_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d/%0d exp=0/0", exp_q.size(), drop_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
